// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: states, opcodes, IR fields.
package cpu_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    // Execute-phase shape of an instruction; ClsNone covers NOP, HALT and undefined opcodes.
    typedef enum logic [1:0] {
        ClsAlu3,
        ClsMulDiv,
        ClsUnary,
        ClsNone
    } op_class_e;

    localparam int unsigned NumRegs  = 16;
    localparam int unsigned RegAddrW = 4;
    localparam int unsigned OpW      = 5;

    localparam int unsigned OpMsb = 31;
    localparam int unsigned OpLsb = 27;
    localparam int unsigned RaMsb = 26;
    localparam int unsigned RaLsb = 23;
    localparam int unsigned RbMsb = 22;
    localparam int unsigned RbLsb = 19;
    localparam int unsigned RcMsb = 18;
    localparam int unsigned RcLsb = 15;

    // ALU codes equal these opcodes.
    localparam logic [OpW-1:0] OpAdd  = 5'b00011;
    localparam logic [OpW-1:0] OpSub  = 5'b00100;
    localparam logic [OpW-1:0] OpShr  = 5'b00101;
    localparam logic [OpW-1:0] OpShl  = 5'b00110;
    localparam logic [OpW-1:0] OpRor  = 5'b00111;
    localparam logic [OpW-1:0] OpRol  = 5'b01000;
    localparam logic [OpW-1:0] OpAnd  = 5'b01001;
    localparam logic [OpW-1:0] OpOr   = 5'b01010;
    localparam logic [OpW-1:0] OpMul  = 5'b01110;
    localparam logic [OpW-1:0] OpDiv  = 5'b01111;
    localparam logic [OpW-1:0] OpNeg  = 5'b10000;
    localparam logic [OpW-1:0] OpNot  = 5'b10001;
    localparam logic [OpW-1:0] OpNop  = 5'b11010;
    localparam logic [OpW-1:0] OpHalt = 5'b11011;

    function automatic op_class_e op_class(input logic [OpW-1:0] op);
        op_class_e cls;
        unique case (op)
            OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: cls = ClsAlu3;
            OpMul, OpDiv:                                          cls = ClsMulDiv;
            OpNeg, OpNot:                                          cls = ClsUnary;
            default:                                               cls = ClsNone;
        endcase
        return cls;
    endfunction

    function automatic logic op_defined(input logic [OpW-1:0] op);
        return (op_class(op) != ClsNone) || (op == OpNop) || (op == OpHalt);
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot general-register select with enable.
module reg_select_decoder
    import cpu_pkg::*;
(
    input  logic                en_i,
    input  logic [RegAddrW-1:0] sel_i,
    output logic [NumRegs-1:0]  onehot_o
);

    // Single set bit at sel_i when enabled, otherwise all zero.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = NumRegs'(1) << sel_i;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T2, execute T3-T6, Moore outputs plus IR decode.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic        MemReady,
    input  logic [31:0] IR,
    output logic        PC_Out,
    output logic        ZLO_Out,
    output logic        ZHI_Out,
    output logic        MDR_Out,
    output logic        MAR_In,
    output logic        PC_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        Z_In,
    output logic        LO_In,
    output logic        HI_In,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] R_Out,
    output logic [15:0] R_In,
    output logic [4:0]  CONTROL,
    output logic        Done,
    output logic        Halted,
    output logic        IllegalOp
);

    state_e               state_q, state_d;
    logic [OpW-1:0]       opcode;
    logic [RegAddrW-1:0]  ra, rb, rc;
    op_class_e            op_cls;
    logic                 r_out_en, r_in_en, done, illegal;
    logic [RegAddrW-1:0]  r_out_sel, r_in_sel;
    logic                 unused_ir;

    assign opcode    = IR[OpMsb:OpLsb];
    assign ra        = IR[RaMsb:RaLsb];
    assign rb        = IR[RbMsb:RbLsb];
    assign rc        = IR[RcMsb:RcLsb];
    assign op_cls    = op_class(opcode);
    assign unused_ir = ^IR[RcLsb-1:0];
    assign Done      = done;
    assign IllegalOp = illegal;

    // State register; Clear drops straight to IDLE, which decodes to all-zero outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode from the current state and IR.
    always_comb begin
        state_d   = state_q;
        PC_Out    = 1'b0;
        ZLO_Out   = 1'b0;
        ZHI_Out   = 1'b0;
        MDR_Out   = 1'b0;
        MAR_In    = 1'b0;
        PC_In     = 1'b0;
        MDR_In    = 1'b0;
        IR_In     = 1'b0;
        Y_In      = 1'b0;
        Z_In      = 1'b0;
        LO_In     = 1'b0;
        HI_In     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        CONTROL   = '0;
        Halted    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        r_out_en  = 1'b0;
        r_out_sel = '0;
        r_in_en   = 1'b0;
        r_in_sel  = '0;

        unique case (state_q)
            StIdle: begin
                if (Run) state_d = StT0;
            end
            StT0: begin
                PC_Out  = 1'b1;
                MAR_In  = 1'b1;
                IncPC   = 1'b1;
                Z_In    = 1'b1;
                state_d = StT1;
            end
            StT1: begin
                // Reloading PC and MDR while stalled is harmless: Z does not change.
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
                if (MemReady) state_d = StT2;
            end
            StT2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                state_d = StT4;
                unique case (op_cls)
                    ClsAlu3: begin
                        r_out_en  = 1'b1;
                        r_out_sel = rb;
                        Y_In      = 1'b1;
                    end
                    ClsMulDiv: begin
                        r_out_en  = 1'b1;
                        r_out_sel = ra;
                        Y_In      = 1'b1;
                    end
                    ClsUnary: begin
                        r_out_en  = 1'b1;
                        r_out_sel = rb;
                        CONTROL   = opcode;
                        Z_In      = 1'b1;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = !op_defined(opcode);
                    end
                endcase
            end
            StT4: begin
                state_d = StT5;
                unique case (op_cls)
                    ClsAlu3: begin
                        r_out_en  = 1'b1;
                        r_out_sel = rc;
                        CONTROL   = opcode;
                        Z_In      = 1'b1;
                    end
                    ClsMulDiv: begin
                        r_out_en  = 1'b1;
                        r_out_sel = rb;
                        CONTROL   = opcode;
                        Z_In      = 1'b1;
                    end
                    ClsUnary: begin
                        ZLO_Out  = 1'b1;
                        r_in_en  = 1'b1;
                        r_in_sel = ra;
                        done     = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StT5: begin
                state_d = StT6;
                unique case (op_cls)
                    ClsAlu3: begin
                        ZLO_Out  = 1'b1;
                        r_in_en  = 1'b1;
                        r_in_sel = ra;
                        done     = 1'b1;
                    end
                    ClsMulDiv: begin
                        ZLO_Out = 1'b1;
                        LO_In   = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StT6: begin
                ZHI_Out = 1'b1;
                HI_In   = 1'b1;
                done    = 1'b1;
            end
            StHalt: begin
                Halted = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Instruction boundary: Run is only sampled here and in IDLE.
        if (done) begin
            if (opcode == OpHalt) begin
                state_d = StHalt;
            end else begin
                state_d = Run ? StT0 : StIdle;
            end
        end
    end

    reg_select_decoder u_r_out_dec (
        .en_i     (r_out_en),
        .sel_i    (r_out_sel),
        .onehot_o (R_Out)
    );

    reg_select_decoder u_r_in_dec (
        .en_i     (r_in_en),
        .sel_i    (r_in_sel),
        .onehot_o (R_In)
    );

endmodule
